// File: rtl/phase_sequencer_pkg.sv
// Shared types for the LEGv8 phase sequencer: sequencer state, default phase indices, phase-register width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package legv8_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } seq_state_t;

  // Default stage positions for the classic five-phase nonpipelined datapath.
  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_MEM    = 3;
  localparam int PH_WB     = 4;

  // Width of a register holding a phase index 0..num_phases-1.
  function automatic int phase_w(input int num_phases);
    return (num_phases > 1) ? $clog2(num_phases) : 1;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Datapath-facing bundle of the phase sequencer: stage enables out, memory/decoder handshakes in.
// Latency: n/a (wiring only).
// Backpressure: imem_ready / dmem_ready stretch the fetch and memory phases.
// Ports: imem_ready, dmem_ready, mem_access, halt_req (datapath -> sequencer);
//        phase_en, pc_write (sequencer -> datapath).
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 5
);
  logic                  imem_ready;
  logic                  dmem_ready;
  logic                  mem_access;
  logic                  halt_req;
  logic [NUM_PHASES-1:0] phase_en;
  logic                  pc_write;

  modport master (
    input  imem_ready, dmem_ready, mem_access, halt_req,
    output phase_en, pc_write
  );

  modport slave (
    output imem_ready, dmem_ready, mem_access, halt_req,
    input  phase_en, pc_write
  );
endinterface

// File: rtl/phase_sequencer_stall_watchdog.sv
// Counts consecutive stall cycles and flags the one that exhausts the TIMEOUT budget.
// Latency: expired is combinational from the count register and incr (same cycle as the stall).
// Backpressure: none; clear has priority over incr. TIMEOUT=0 disables it entirely.
// Ports: clk, reset (sync, active-low), clear, incr, expired.
module stall_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  // expired marks the hold cycle that is the TIMEOUT-th in a row, so the
  // owner can leave for FAULT on that edge and flag it the following cycle.
  assign expired = (TIMEOUT != 0) && incr && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (TIMEOUT != 0) && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase-enable sequencer for the nonpipelined LEGv8 datapath with run/step, budget, halt and watchdog.
// Latency: outputs decode from registers only; run sampled in IDLE -> phase_en[0] next cycle; NUM_PHASES cycles/instr.
// Backpressure: imem_ready holds fetch, dmem_ready holds the memory phase when mem_access; each hold adds one cycle.
// Ports: clk, reset (sync, active-low), run, single_step, step, bus (master modport),
//        busy, halted, fault, instr_count.
module phase_sequencer
  import legv8_seq_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int MEM_PHASE  = PH_MEM,
  parameter int CNT_W      = 32,
  parameter int MAX_INSTR  = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  single_step,
  input  logic                  step,
  phase_sequencer_if.master     bus,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault,
  output logic [CNT_W-1:0]      instr_count
);
  localparam int PW = phase_w(NUM_PHASES);
  localparam logic [PW-1:0] LAST_PH = PW'(NUM_PHASES - 1);
  localparam logic [PW-1:0] MEM_PH  = PW'(MEM_PHASE);
  localparam logic [PW-1:0] FET_PH  = PW'(PH_FETCH);

  seq_state_t            state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [CNT_W-1:0]      count_q, count_d, count_inc;
  logic                  advance;
  logic                  hold;
  logic                  wd_expired;
  logic [NUM_PHASES-1:0] phase_en;

  // Saturating retire count: all-ones sticks rather than wrapping.
  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

  // Only fetch and the memory phase can be stretched; the rest last one cycle.
  always_comb begin
    advance = 1'b1;
    if (phase_q == FET_PH) begin
      advance = bus.imem_ready;
    end else if (phase_q == MEM_PH) begin
      advance = !bus.mem_access || bus.dmem_ready;
    end
  end

  assign hold = (state_q == ST_RUN) && !advance;

  stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!hold),
    .incr    (hold),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        // In single-step mode only a step pulse starts work; run is ignored.
        if (single_step ? step : run) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hold) begin
          if (wd_expired) begin
            state_d = ST_FAULT;
          end
        end else if (phase_q == LAST_PH) begin
          // Retire: the count moves even when this retire also halts.
          count_d = count_inc;
          phase_d = '0;
          if (bus.halt_req || ((MAX_INSTR != 0) && (count_inc == CNT_W'(MAX_INSTR)))) begin
            state_d = ST_HALTED;
          end else if (single_step || !run) begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_HALTED, ST_FAULT: begin
        // Sticky until reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    phase_en = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      phase_en[i] = (state_q == ST_RUN) && (phase_q == PW'(i));
    end
  end

  assign bus.phase_en = phase_en;
  assign bus.pc_write = phase_en[NUM_PHASES-1];
  assign busy         = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALTED);
  assign fault        = (state_q == ST_FAULT);
  assign instr_count  = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a vector table for the basic walk, stalls and run-drop,
// then hand-written sequences for single-step, halt, budget, saturation, watchdog and reset.
// Three instances share the stimulus: default, MAX_INSTR=7, and CNT_W=2 for saturation.
module tb_phase_sequencer;
  import legv8_seq_pkg::*;

  localparam int NP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run, single_step, step;
  logic imem_ready, dmem_ready, mem_access, halt_req;

  logic        busy, halted, fault;
  logic [31:0] instr_count;
  logic        busy7, halted7, fault7;
  logic [31:0] count7;
  logic        busy_s, halted_s, fault_s;
  logic [1:0]  count_s;

  phase_sequencer_if #(.NUM_PHASES(NP)) bus ();
  phase_sequencer_if #(.NUM_PHASES(NP)) bus7 ();
  phase_sequencer_if #(.NUM_PHASES(NP)) bus_s ();

  assign bus.imem_ready   = imem_ready;
  assign bus.dmem_ready   = dmem_ready;
  assign bus.mem_access   = mem_access;
  assign bus.halt_req     = halt_req;
  assign bus7.imem_ready  = imem_ready;
  assign bus7.dmem_ready  = dmem_ready;
  assign bus7.mem_access  = mem_access;
  assign bus7.halt_req    = halt_req;
  assign bus_s.imem_ready = imem_ready;
  assign bus_s.dmem_ready = dmem_ready;
  assign bus_s.mem_access = mem_access;
  assign bus_s.halt_req   = halt_req;

  phase_sequencer #(.NUM_PHASES(NP), .MEM_PHASE(3), .CNT_W(32), .MAX_INSTR(0), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .single_step(single_step), .step(step),
    .bus(bus), .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  phase_sequencer #(.NUM_PHASES(NP), .MEM_PHASE(3), .CNT_W(32), .MAX_INSTR(7), .TIMEOUT(16)) dut7 (
    .clk(clk), .reset(reset), .run(run), .single_step(single_step), .step(step),
    .bus(bus7), .busy(busy7), .halted(halted7), .fault(fault7), .instr_count(count7)
  );

  phase_sequencer #(.NUM_PHASES(NP), .MEM_PHASE(3), .CNT_W(2), .MAX_INSTR(0), .TIMEOUT(16)) dut_s (
    .clk(clk), .reset(reset), .run(run), .single_step(single_step), .step(step),
    .bus(bus_s), .busy(busy_s), .halted(halted_s), .fault(fault_s), .instr_count(count_s)
  );

  typedef struct {
    logic       rst, run, ss, step, im, dm, ma, hr;
    logic [4:0] pe;
    logic       busy, halted, fault;
    int         cnt;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   pulses;
  int   n;
  vec_t vt[24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    reset = 1'b0; run = 1'b0; single_step = 1'b0; step = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1; mem_access = 1'b0; halt_req = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_pe(input logic [4:0] target, input string name);
    int k = 0;
    while (bus.phase_en !== target && k < 50) begin
      tick();
      k++;
    end
    check(name, {59'd0, bus.phase_en}, {59'd0, target});
  endtask

  function automatic vec_t mk(input logic [7:0] in, input logic [4:0] pe,
                              input logic b, input logic h, input logic f, input int c);
    vec_t v;
    {v.rst, v.run, v.ss, v.step, v.im, v.dm, v.ma, v.hr} = in;
    v.pe = pe; v.busy = b; v.halted = h; v.fault = f; v.cnt = c;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // inputs: rst run ss step im dm ma hr
    vt[0]  = mk(8'b0000_1100, 5'b00000, 0, 0, 0, 0); // reset asserted
    vt[1]  = mk(8'b1000_1100, 5'b00000, 0, 0, 0, 0); // idle, run low
    vt[2]  = mk(8'b1100_1100, 5'b00001, 1, 0, 0, 0); // run -> fetch next cycle
    vt[3]  = mk(8'b1100_1100, 5'b00010, 1, 0, 0, 0);
    vt[4]  = mk(8'b1100_1100, 5'b00100, 1, 0, 0, 0);
    vt[5]  = mk(8'b1100_1100, 5'b01000, 1, 0, 0, 0);
    vt[6]  = mk(8'b1100_1100, 5'b10000, 1, 0, 0, 0); // writeback, pc_write
    vt[7]  = mk(8'b1100_1100, 5'b00001, 1, 0, 0, 1); // no bubble
    vt[8]  = mk(8'b1100_0100, 5'b00001, 1, 0, 0, 1); // imem stall x3
    vt[9]  = mk(8'b1100_0100, 5'b00001, 1, 0, 0, 1);
    vt[10] = mk(8'b1100_0100, 5'b00001, 1, 0, 0, 1);
    vt[11] = mk(8'b1100_1100, 5'b00010, 1, 0, 0, 1);
    vt[12] = mk(8'b1100_1100, 5'b00100, 1, 0, 0, 1);
    vt[13] = mk(8'b1100_1010, 5'b01000, 1, 0, 0, 1); // exec advances regardless of ma
    vt[14] = mk(8'b1100_1010, 5'b01000, 1, 0, 0, 1); // dmem stall x2
    vt[15] = mk(8'b1100_1010, 5'b01000, 1, 0, 0, 1);
    vt[16] = mk(8'b1100_1110, 5'b10000, 1, 0, 0, 1);
    vt[17] = mk(8'b1100_1100, 5'b00001, 1, 0, 0, 2);
    vt[18] = mk(8'b1000_1100, 5'b00010, 1, 0, 0, 2); // run drop does not abort
    vt[19] = mk(8'b1000_1101, 5'b00100, 1, 0, 0, 2); // halt_req outside WB ignored
    vt[20] = mk(8'b1000_1100, 5'b01000, 1, 0, 0, 2);
    vt[21] = mk(8'b1000_1100, 5'b10000, 1, 0, 0, 2);
    vt[22] = mk(8'b1000_1100, 5'b00000, 0, 0, 0, 3); // back to IDLE
    vt[23] = mk(8'b1000_1100, 5'b00000, 0, 0, 0, 3);

    for (int i = 0; i < 24; i++) begin
      {reset, run, single_step, step, imem_ready, dmem_ready, mem_access, halt_req} =
        {vt[i].rst, vt[i].run, vt[i].ss, vt[i].step, vt[i].im, vt[i].dm, vt[i].ma, vt[i].hr};
      tick();
      check($sformatf("v%0d_phase_en", i), {59'd0, bus.phase_en}, {59'd0, vt[i].pe});
      check($sformatf("v%0d_pc_write", i), {63'd0, bus.pc_write}, {63'd0, vt[i].pe[4]});
      check($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, vt[i].busy});
      check($sformatf("v%0d_halted", i), {63'd0, halted}, {63'd0, vt[i].halted});
      check($sformatf("v%0d_fault", i), {63'd0, fault}, {63'd0, vt[i].fault});
      check($sformatf("v%0d_count", i), {32'd0, instr_count}, 64'(vt[i].cnt));
    end

    // Continuous run: 20 RUN cycles retire 4; the 2-bit counter saturates at 3.
    reset_all();
    run = 1'b1;
    tick();
    check("a_first_fetch", {59'd0, bus.phase_en}, 64'h01);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.pc_write) pulses++;
      tick();
    end
    check("a_pulses", 64'(pulses), 64'd4);
    check("a_count", {32'd0, instr_count}, 64'd4);
    check("a_phase_en", {59'd0, bus.phase_en}, 64'h01);
    check("a_sat_count", {62'd0, count_s}, 64'd3);

    // Single step: run is ignored, each step pulse retires exactly one instruction.
    reset_all();
    single_step = 1'b1;
    run = 1'b1;
    repeat (3) tick();
    check("b_run_ignored", {63'd0, busy}, 64'd0);
    run = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      check($sformatf("b_start%0d", k), {63'd0, busy}, 64'd1);
      step = 1'b0;
      for (int i = 0; i < 19; i++) begin
        if (bus.pc_write) pulses++;
        tick();
      end
      check($sformatf("b_idle%0d", k), {63'd0, busy}, 64'd0);
    end
    check("b_pulses", 64'(pulses), 64'd3);
    check("b_count", {32'd0, instr_count}, 64'd3);

    // halt_req at the second writeback.
    reset_all();
    run = 1'b1;
    n = 0;
    while (!(bus.pc_write && instr_count == 32'd1) && n < 40) begin
      tick();
      n++;
    end
    check("c_second_wb", {63'd0, bus.pc_write}, 64'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("c_halted", {63'd0, halted}, 64'd1);
    check("c_count", {32'd0, instr_count}, 64'd2);
    check("c_phase_en", {59'd0, bus.phase_en}, 64'd0);
    step = 1'b1;
    repeat (5) tick();
    step = 1'b0;
    check("c_sticky", {63'd0, halted}, 64'd1);
    check("c_busy_after", {63'd0, busy}, 64'd0);
    check("c_count_after", {32'd0, instr_count}, 64'd2);

    // Budget of 7, with halt_req also raised on the 7th retire.
    reset_all();
    run = 1'b1;
    pulses = 0;
    n = 0;
    while (!halted7 && n < 100) begin
      if (bus7.pc_write) pulses++;
      halt_req = bus7.pc_write && (count7 == 32'd6);
      tick();
      n++;
    end
    halt_req = 1'b0;
    check("d_halted", {63'd0, halted7}, 64'd1);
    check("d_retired", 64'(pulses), 64'd7);
    check("d_count", {32'd0, count7}, 64'd7);
    check("d_cycles", 64'(n), 64'd36);
    repeat (5) tick();
    check("d_count_hold", {32'd0, count7}, 64'd7);

    // Watchdog: dmem never ready.
    reset_all();
    run = 1'b1;
    mem_access = 1'b1;
    dmem_ready = 1'b0;
    wait_pe(5'b01000, "e_reach_mem");
    repeat (15) tick();
    check("e_no_fault_yet", {63'd0, fault}, 64'd0);
    check("e_still_mem", {59'd0, bus.phase_en}, 64'h08);
    tick();
    check("e_fault", {63'd0, fault}, 64'd1);
    check("e_phase_off", {59'd0, bus.phase_en}, 64'd0);
    check("e_not_busy", {63'd0, busy}, 64'd0);
    dmem_ready = 1'b1;
    mem_access = 1'b0;
    repeat (4) tick();
    check("e_sticky", {63'd0, fault}, 64'd1);
    reset = 1'b0;
    tick();
    check("e_reset_fault", {63'd0, fault}, 64'd0);
    check("e_reset_phase", {59'd0, bus.phase_en}, 64'd0);
    check("e_reset_busy", {63'd0, busy}, 64'd0);
    check("e_reset_halted", {63'd0, halted}, 64'd0);
    reset = 1'b1;
    run = 1'b0;
    tick();
    check("e_idle", {63'd0, busy}, 64'd0);

    // Reset mid-instruction at phase 2.
    reset_all();
    run = 1'b1;
    wait_pe(5'b00100, "f_reach_exec");
    reset = 1'b0;
    tick();
    check("f_phase_off", {59'd0, bus.phase_en}, 64'd0);
    check("f_pc_write", {63'd0, bus.pc_write}, 64'd0);
    check("f_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;
    run = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.pc_write) pulses++;
      tick();
    end
    check("f_no_pc_write", 64'(pulses), 64'd0);
    check("f_count", {32'd0, instr_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
